ram_port_arbiter: RTL

//  Shares the single-port synchronous RAM between two requesters: the CPU

---
 rtl/ram_port_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port synchronous RAM between the CPU control FSM (port C)
// and a host/debug loader (port D). Serialises req/ack transactions, registers
// the RAM address/data and counts out the RAM read latency so that requesters
// simply wait for their ack pulse.
module ram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2   // legal range 1..7; the wait counter is 3 bits wide
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_c_req,
  input  logic              i_c_we,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_wdata,
  output logic              o_c_ack,
  output logic [DATA_W-1:0] o_c_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  output logic              o_ram_wren,
  input  logic [DATA_W-1:0] i_ram_q,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  // Last WAIT count: i_ram_q is captured on the clock that ends this count.
  localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

  state_t      state_r;
  logic        winner_r;      // 1'b1 = port D owns the current transaction
  logic        last_grant_r;  // 1'b1 = port D was granted most recently
  logic        we_r;
  logic [2:0]  cnt_r;

  logic              grant_d_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  // Pick the winner (round robin on a tie) and mux its request fields.
  always_comb begin
    grant_d_s   = 1'b0;
    sel_we_s    = i_c_we;
    sel_addr_s  = i_c_addr;
    sel_wdata_s = i_c_wdata;
    if (i_d_req && (!i_c_req || !last_grant_r)) begin
      grant_d_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
    end
    if (grant_d_s) begin
      sel_we_s    = i_d_we;
      sel_addr_s  = i_d_addr;
      sel_wdata_s = i_d_wdata;
    end else begin
      sel_we_s    = i_c_we;
      sel_addr_s  = i_c_addr;
      sel_wdata_s = i_c_wdata;
    end
  end

  // Transaction FSM with all outputs registered; wren/ack default low each cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r      <= S_IDLE;
      winner_r     <= 1'b0;
      last_grant_r <= 1'b1;
      we_r         <= 1'b0;
      cnt_r        <= 3'd0;
      o_c_ack      <= 1'b0;
      o_d_ack      <= 1'b0;
      o_c_rdata    <= '0;
      o_d_rdata    <= '0;
      o_ram_addr   <= '0;
      o_ram_data   <= '0;
      o_ram_wren   <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_ram_wren <= 1'b0;
      o_c_ack    <= 1'b0;
      o_d_ack    <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (i_c_req || i_d_req) begin
            winner_r     <= grant_d_s;
            last_grant_r <= grant_d_s;
            we_r         <= sel_we_s;
            o_ram_addr   <= sel_addr_s;
            o_ram_data   <= sel_wdata_s;
            o_ram_wren   <= sel_we_s;
            o_busy       <= 1'b1;
            state_r      <= S_ACCESS;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ACCESS: begin
          cnt_r <= 3'd0;
          if (we_r) begin
            if (winner_r) begin
              o_d_ack <= 1'b1;
            end else begin
              o_c_ack <= 1'b1;
            end
            state_r <= S_ACK;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_r <= cnt_r + 3'd1;
          if (cnt_r == LAST_CNT) begin
            if (winner_r) begin
              o_d_rdata <= i_ram_q;
              o_d_ack   <= 1'b1;
            end else begin
              o_c_rdata <= i_ram_q;
              o_c_ack   <= 1'b1;
            end
            state_r <= S_ACK;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_ACK: begin
          o_busy  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
